// File: rtl/param_fetch_sequencer.sv
// Fetches a contiguous run of parameter bytes from data_memory and replays them
// downstream as a valid/ready stream with a last marker, buffering in a small FWFT FIFO.
module param_fetch_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            req_layer,
  input  logic [ADDR_WIDTH-1:0] req_base,
  input  logic [ADDR_WIDTH:0]   req_len,
  output logic [5:0]            mem_layer_select,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_WIDTH:0]   LEN_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH+1:0] ADDR_SPAN  = (ADDR_WIDTH + 2)'(1) << ADDR_WIDTH;
  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

  logic [1:0]            state;
  logic                  fin_hold;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  cap_valid;
  logic                  cap_last;
  logic [CNT_W-1:0]      outstanding;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic [ADDR_WIDTH+1:0] req_end;
  logic                  range_ok;
  logic                  accept_fetch;
  logic                  can_issue;
  logic                  issue;
  logic                  issue_any;
  logic                  push;
  logic                  pop;

  assign req_end      = {2'b00, req_base} + {1'b0, req_len};
  assign range_ok     = (req_end <= ADDR_SPAN);
  assign accept_fetch = (state == S_IDLE) && start && (req_len != '0) && range_ok;

  // outstanding counts FIFO entries plus reads still in the ROM pipeline, so a
  // granted issue always has a slot waiting for its data.
  assign can_issue = (remaining != '0) && ((outstanding - CNT_W'(pop)) < FULL_COUNT);
  assign issue     = (state == S_ISSUE) && can_issue;
  assign issue_any = accept_fetch || issue;

  assign push      = cap_valid;
  assign pop       = out_valid && out_ready;
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN) && !fin_hold;

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      fin_hold         <= 1'b0;
      remaining        <= '0;
      rd_valid         <= 1'b0;
      rd_last          <= 1'b0;
      cap_valid        <= 1'b0;
      cap_last         <= 1'b0;
      outstanding      <= '0;
      mem_addr         <= '0;
      mem_layer_select <= '0;
      error            <= 1'b0;
    end else begin
      error       <= 1'b0;
      rd_valid    <= issue_any;
      rd_last     <= accept_fetch ? (req_len == LEN_ONE) : (issue && (remaining == LEN_ONE));
      cap_valid   <= rd_valid;
      cap_last    <= rd_last;
      outstanding <= outstanding + (issue_any ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

      case (state)
        S_IDLE: begin
          if (start) begin
            if (req_len == '0) begin
              // Zero-length requests still report completion, one cycle later.
              mem_layer_select <= req_layer;
              fin_hold         <= 1'b1;
              state            <= S_FIN;
            end else if (!range_ok) begin
              error <= 1'b1;
            end else begin
              mem_layer_select <= req_layer;
              mem_addr         <= req_base;
              remaining        <= req_len - LEN_ONE;
              state            <= (req_len == LEN_ONE) ? S_DRAIN : S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (can_issue) begin
            mem_addr  <= mem_addr + ADDR_ONE;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && out_last) state <= S_FIN;
        end
        S_FIN: begin
          if (fin_hold) fin_hold <= 1'b0;
          else          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only
  // observable through out_valid, which the reset of fifo_count clears.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_data;
      fifo_last[wr_ptr] <= cap_last;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      fifo_no_overflow: assert (!(push && !pop && fifo_count == FULL_COUNT));
    end
  end

endmodule

// File: tb/tb_param_fetch_sequencer.sv
// Directed bench for param_fetch_sequencer with a registered, layer-muxed ROM model
// standing in for data_memory.
module tb_param_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  req_layer;
  logic [17:0] req_base;
  logic [18:0] req_len;
  logic [5:0]  mem_layer_select;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;

  param_fetch_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(18), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .req_layer(req_layer), .req_base(req_base),
    .req_len(req_len), .mem_layer_select(mem_layer_select), .mem_addr(mem_addr),
    .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: address registered, layer muxed combinationally on the output.
  function automatic logic [7:0] rom_byte(input logic [5:0] layer, input logic [17:0] addr);
    return addr[7:0] ^ addr[17:10] ^ {layer, 2'b01};
  endfunction

  logic [17:0] addr_q;
  always @(posedge clk) addr_q <= mem_addr;
  assign mem_data = rom_byte(mem_layer_select, addr_q);

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    req_layer = '0; req_base = '0; req_len = '0;
    tick; tick;
    n_checks++;
    if ({out_valid, out_last, busy, done, error} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {out_valid, out_last, busy, done, error});
    else n_pass++;
    n_checks++;
    if ({out_data, mem_addr, mem_layer_select} !== 32'h0)
      $display("FAIL reset_buses: got %h want 0", {out_data, mem_addr, mem_layer_select});
    else n_pass++;
    rst = 1'b0;
    tick;
  endtask

  // Full request with out_ready high; optionally hammers start with another request while busy.
  // Entered and left at the negedge of an IDLE cycle.
  task automatic run_fetch(input string name, input logic [5:0] layer, input logic [17:0] base,
                           input int len, input bit disturb);
    logic [2:0]  exp_f;
    logic [17:0] exp_addr;
    logic [7:0]  exp_data;
    req_layer = layer; req_base = base; req_len = 19'(len);
    start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= len + 3; c++) begin
      tick;
      start = 1'b0;
      if (disturb && c >= 2) begin
        start = 1'b1; req_layer = 6'd30; req_base = 18'h00300; req_len = 19'd2;
      end
      n_checks++;
      if (busy !== 1'b1) $display("FAIL %s busy c=%0d: got %b want 1", name, c, busy);
      else n_pass++;
      n_checks++;
      if (mem_layer_select !== layer)
        $display("FAIL %s layer_select c=%0d: got %0d want %0d", name, c, mem_layer_select, layer);
      else n_pass++;
      if (c <= len) begin
        exp_addr = base + 18'(c - 1);
        n_checks++;
        if (mem_addr !== exp_addr)
          $display("FAIL %s mem_addr c=%0d: got %h want %h", name, c, mem_addr, exp_addr);
        else n_pass++;
      end
      exp_f = {(c >= 3 && c <= len + 2), (c == len + 2), (c == len + 3)};
      n_checks++;
      if ({out_valid, out_last, done} !== exp_f)
        $display("FAIL %s valid_last_done c=%0d: got %b want %b", name, c,
                 {out_valid, out_last, done}, exp_f);
      else n_pass++;
      if (exp_f[2]) begin
        exp_data = rom_byte(layer, base + 18'(c - 3));
        n_checks++;
        if (out_data !== exp_data)
          $display("FAIL %s out_data c=%0d: got %h want %h", name, c, out_data, exp_data);
        else n_pass++;
      end
    end
    tick;
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL %s idle_after: got %b want 00", name, {busy, done});
    else n_pass++;
  endtask

  task automatic test_basic;
    run_fetch("basic", 6'd16, 18'h00000, 4, 1'b0);
  endtask

  task automatic test_backpressure;
    int beats = 0;
    bit sel_ok = 1'b1;
    bit done_seen = 1'b0;
    logic [7:0] exp_data;
    req_layer = 6'd16; req_base = 18'h00100; req_len = 19'd10;
    start = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      tick;
      start = 1'b0;
      out_ready = (c >= 13);
      if (mem_layer_select !== 6'd16) sel_ok = 1'b0;
      if (c == 8 || c == 13) begin
        n_checks++;
        if (mem_addr !== 18'h00103)
          $display("FAIL bp_stall_addr c=%0d: got %h want 00103", c, mem_addr);
        else n_pass++;
      end
      if (c == 14) begin
        n_checks++;
        if (mem_addr !== 18'h00104) $display("FAIL bp_resume_addr: got %h want 00104", mem_addr);
        else n_pass++;
      end
      if (done === 1'b1) begin
        done_seen = 1'b1;
        n_checks++;
        if (beats !== 10) $display("FAIL bp_beats_at_done: got %0d want 10", beats);
        else n_pass++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        exp_data = rom_byte(6'd16, 18'h00100 + 18'(beats));
        n_checks++;
        if ({out_data, out_last} !== {exp_data, beats == 9})
          $display("FAIL bp_beat%0d: got %h/%b want %h/%b", beats, out_data, out_last,
                   exp_data, beats == 9);
        else n_pass++;
        beats++;
      end
    end
    n_checks++;
    if (done_seen !== 1'b1) $display("FAIL bp_done: got no done within 40 cycles want done");
    else n_pass++;
    n_checks++;
    if (sel_ok !== 1'b1) $display("FAIL bp_layer_select: got a change want steady 16");
    else n_pass++;
    tick;
  endtask

  task automatic test_range_error;
    req_layer = 6'd20; req_base = 18'h3FFFE; req_len = 19'd3;
    start = 1'b1; out_ready = 1'b1;
    tick;
    start = 1'b0;
    n_checks++;
    if ({error, busy} !== 2'b10) $display("FAIL range_err_pulse: got %b want 10", {error, busy});
    else n_pass++;
    n_checks++;
    if (mem_addr !== 18'h00109) $display("FAIL range_mem_addr: got %h want 00109", mem_addr);
    else n_pass++;
    for (int c = 2; c <= 4; c++) begin
      tick;
      n_checks++;
      if ({error, busy, out_valid, done} !== 4'b0)
        $display("FAIL range_quiet c=%0d: got %b want 0000", c, {error, busy, out_valid, done});
      else n_pass++;
    end
  endtask

  task automatic test_zero_len;
    logic [2:0] exp_f;
    req_layer = 6'd20; req_base = 18'h00123; req_len = 19'd0;
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      start = 1'b0;
      exp_f = {c <= 2, c == 2, 1'b0};
      n_checks++;
      if ({busy, done, out_valid} !== exp_f)
        $display("FAIL zero_len c=%0d: got %b want %b", c, {busy, done, out_valid}, exp_f);
      else n_pass++;
    end
  endtask

  task automatic test_upper_bound;
    run_fetch("upper", 6'd52, 18'h3FFFC, 4, 1'b0);
  endtask

  task automatic test_start_while_busy;
    run_fetch("start_busy", 6'd16, 18'h00200, 6, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_fetch("b2b_first", 6'd8, 18'h01000, 3, 1'b0);
    run_fetch("b2b_second", 6'd9, 18'h02000, 5, 1'b0);
  endtask

  task automatic test_reset_mid;
    req_layer = 6'd16; req_base = 18'h00040; req_len = 19'd8;
    start = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick;
      start = 1'b0;
    end
    n_checks++;
    if ({out_valid, busy} !== 2'b11) $display("FAIL rmid_pre: got %b want 11", {out_valid, busy});
    else n_pass++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if ({out_valid, out_last, busy, done, error} !== 5'b0)
      $display("FAIL rmid_flags: got %b want 00000", {out_valid, out_last, busy, done, error});
    else n_pass++;
    n_checks++;
    if ({out_data, mem_addr, mem_layer_select} !== 32'h0)
      $display("FAIL rmid_buses: got %h want 0", {out_data, mem_addr, mem_layer_select});
    else n_pass++;
    tick;
    n_checks++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL rmid_flushed: got %b want 00", {out_valid, busy});
    else n_pass++;
    run_fetch("after_reset", 6'd16, 18'h00010, 2, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_range_error();
    test_zero_len();
    test_upper_bound();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_fetch_sequencer.md
# param_fetch_sequencer

Streams a contiguous run of parameter bytes out of `data_memory` for the CNN compute datapath. Given a layer code, base address and length, it drives `layer_select`/`addr` into `data_memory`, absorbs the one-cycle ROM read latency, and buffers the returned bytes. It delivers them downstream as a valid/ready stream with a last marker. It sits directly upstream of `data_memory` on the address side and directly downstream of it on the data side.

## Interface
- `DATA_WIDTH`, 8, parameter byte width; matches `data_memory`.
- `ADDR_WIDTH`, 18, address width; matches `data_memory`.
- `FIFO_DEPTH`, 4, output buffer entries; power of two, ≥ 2.
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `req_layer`  in  6  layer code to fetch (same encoding as `data_memory`, e.g. 16 = CIFAR conv1 weights).
- `req_base`  in  ADDR_WIDTH  first address.
- `req_len`  in  ADDR_WIDTH+1  number of bytes to fetch.
- `mem_layer_select`  out  6  to `data_memory.layer_select`.
- `mem_addr`  out  ADDR_WIDTH  to `data_memory.addr`.
- `mem_data`  in  DATA_WIDTH  from `data_memory.data_out`.
- `out_data`  out  DATA_WIDTH  stream payload.
- `out_valid`  out  1  payload valid.
- `out_ready`  in  1  downstream accept.
- `out_last`  out  1  marks the final byte of the request.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a request completes.
- `error`  out  1  one-cycle pulse when a request is rejected.

## Operation
- States are IDLE, ISSUE, DRAIN, FIN.
- **IDLE, on `start`:**
  - Latch `req_layer`, `req_base` and `req_len`.
  - If `req_len == 0`, go to FIN. No beats are emitted.
  - Else, if `req_base + req_len > 2^ADDR_WIDTH` (computed ADDR_WIDTH+2 bits wide), pulse `error` next cycle and return to IDLE. No memory reads and no `done` occur.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - Each cycle where `fifo_count + inflight < FIFO_DEPTH`, issue one read: `mem_addr` = current address. Then increment the address and decrement the remaining count.
  - `inflight` is 1 in the cycle after an issue and 0 otherwise.
  - After the last issue, go to DRAIN.
- **DRAIN:** wait until the beat tagged last is handshaken (`out_valid && out_ready && out_last`), then go to FIN.
- **FIN:** pulse `done` for one cycle, then go to IDLE.
- **Capture:** `mem_data` is written into the FIFO in the cycle after the matching issue, together with a last tag. The tag is set when it is the final address of the request.
- **`mem_layer_select`:** held at the latched layer from the accept cycle until IDLE is re-entered. This is mandatory because `data_memory` muxes its registered ROM outputs combinationally on `layer_select`. `mem_layer_select` holds its last value in IDLE.
- **`mem_addr`:** holds its last value when no read is issued.
- **FIFO:**
  - Registered, first-word-fall-through.
  - `out_valid` = FIFO not empty; `out_data` and `out_last` come from the head entry.
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow is impossible by the issue rule; an overflow is a design bug (assertion).
- `start` while `busy` is ignored, with no effect on the request in progress.
- **`rst`:** at any point, including mid-request, the block returns to IDLE, flushes the FIFO and clears `inflight`. Any pending read data is discarded.

## Timing
- Reset values: `out_valid`, `out_last`, `busy`, `done`, `error` = 0; `out_data`, `mem_addr`, `mem_layer_select` = 0.
- Cycle 0: `start` is sampled.
- Cycle 1: `mem_addr = base`; `busy = 1`.
- Cycle 2: `mem_data` is valid and pushed into the FIFO.
- Cycle 3: `out_valid = 1`. Start-to-first-beat latency is 3 cycles.
- Throughput is one byte per cycle while `out_ready` is held high.
- With `out_ready` low, at most `FIFO_DEPTH` bytes are outstanding, after which issuing stalls. Issuing resumes in the cycle after a pop frees space.
- `done` is asserted the cycle after the last handshake. The next `start` can be accepted the cycle after `done`.
- For `len == 0`: `done` is asserted in cycle 2 with `busy` high in cycle 1. For a range error: `error` is asserted in cycle 1 and `busy` stays 0.

## Test plan
- **Basic fetch:** layer 16, base 0, len 4, `out_ready = 1` → 4 beats equal to ROM[0..3] on cycles 3–6. `out_last` is high only on cycle 6, and `done` is high on cycle 7.
- **Backpressure:** len 10, `out_ready` low for cycles 0–12, then high → `mem_addr` stops advancing after 4 issues. All 10 bytes then arrive in order with no loss or duplication. `mem_layer_select` stays 16 throughout.
- **Zero length and range error:**
  - len 0 → no `out_valid`, and `done` is pulsed at cycle 2.
  - base 0x3FFFE, len 3 → `error` is pulsed at cycle 1, with no `done`, no `out_valid` and `mem_addr` unchanged.
- **Upper-bound fetch:** base 0x3FFFC, len 4, layer 52 → addresses 0x3FFFC–0x3FFFF are issued, 4 beats are emitted, and `done` pulses.
- **Start while busy:** a second `start` arrives mid-request with a different layer → it is ignored, and the first request's stream and `mem_layer_select` are unaffected.
- **Reset mid-request:** `rst` is asserted while the FIFO holds 3 bytes → the next cycle shows all outputs at their reset values and the FIFO empty. A new request of len 2 afterwards completes normally.
